// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: load-use and branch-operand stalls, control-transfer flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_detection_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_ex_memRead,
  input  logic             id_ex_regWrite,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_mem_memRead,
  input  logic [4:0]       ex_mem_rd,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state_reg;
  logic [1:0] cnt_reg;
  logic       match_e;
  logic       match_m;
  logic [1:0] n_req;
  logic       stall;

  always_comb begin
    match_e = (id_ex_rd != 5'd0) &&
              ((id_ex_rd == if_id_rs) || (id_uses_rt && (id_ex_rd == if_id_rt)));
    match_m = (ex_mem_rd != 5'd0) &&
              ((ex_mem_rd == if_id_rs) || (id_uses_rt && (ex_mem_rd == if_id_rt)));
    // Later assignments carry the larger stall requirement, giving the maximum.
    n_req = 2'd0;
    if (id_branch && ex_mem_memRead && match_m)                    n_req = 2'd1;
    if (id_branch && id_ex_regWrite && !id_ex_memRead && match_e)  n_req = 2'd1;
    if (id_ex_memRead && match_e)                                  n_req = 2'd1;
    if (id_branch && id_ex_memRead && match_e)                     n_req = 2'd2;
  end

  // Outputs are Mealy in RUN; STALL and reset force the frozen/bubble pattern.
  always_comb begin
    stall        = !rst_n || (state_reg == STALL) || (n_req != 2'd0);
    pc_write     = !stall;
    if_id_write  = !stall;
    id_ex_bubble = stall;
    if_id_flush  = !stall && (branch_taken || jump);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= 2'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (n_req == 2'd2) begin
            state_reg <= STALL;
            cnt_reg   <= 2'd1;
          end
        end
        STALL: begin
          if (cnt_reg == 2'd1) begin
            state_reg <= RUN;
            cnt_reg   <= 2'd0;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        default: begin
          state_reg <= RUN;
          cnt_reg   <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pc_write && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (if_id_flush && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign flush_events = flush_cnt_reg;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: directed scenarios plus randomized traffic against a stall-budget model.
module tb_hazard_detection_unit;

  localparam int CNT_W = 16;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
  logic             id_uses_rt, id_branch, id_ex_memRead, id_ex_regWrite;
  logic             ex_mem_memRead, branch_taken, jump;
  logic             pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_ex_memRead(id_ex_memRead),
    .id_ex_regWrite(id_ex_regWrite), .id_ex_rd(id_ex_rd),
    .ex_mem_memRead(ex_mem_memRead), .ex_mem_rd(ex_mem_rd),
    .branch_taken(branch_taken), .jump(jump),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic set_idle();
    if_id_rs = 5'd0; if_id_rt = 5'd0; id_uses_rt = 1'b0; id_branch = 1'b0;
    id_ex_memRead = 1'b0; id_ex_regWrite = 1'b0; id_ex_rd = 5'd0;
    ex_mem_memRead = 1'b0; ex_mem_rd = 5'd0; branch_taken = 1'b0; jump = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Required stall length derived directly from the hazard rules.
  function automatic int required_stalls();
    bit me, mm;
    int n;
    me = (id_ex_rd != 0) && (id_ex_rd == if_id_rs || (id_uses_rt && id_ex_rd == if_id_rt));
    mm = (ex_mem_rd != 0) && (ex_mem_rd == if_id_rs || (id_uses_rt && ex_mem_rd == if_id_rt));
    n = 0;
    if (id_ex_memRead && me) n = (n > 1) ? n : 1;
    if (id_branch && id_ex_regWrite && !id_ex_memRead && me) n = (n > 1) ? n : 1;
    if (id_branch && id_ex_memRead && me) n = 2;
    if (id_branch && ex_mem_memRead && mm) n = (n > 1) ? n : 1;
    return n;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    branch_taken = 1'b1;
    #1;
    tests_run++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      fails++;
      $display("FAIL reset_outputs: got pc/ifid/bub/flush=%b required 0010",
               {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    tests_run++;
    if (stall_cycles !== '0 || flush_events !== '0) begin
      fails++;
      $display("FAIL reset_counters: got %0d/%0d required 0/0", stall_cycles, flush_events);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    #1;
    tests_run++;
    if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got pc=%b bub=%b required 1/0", pc_write, id_ex_bubble);
    end
  endtask

  task automatic test_load_use();
    reset_pulse();
    id_ex_memRead = 1'b1; id_ex_rd = 5'd8; if_id_rs = 5'd8;
    #1;
    tests_run++;
    if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_bubble !== 1'b1) begin
      fails++;
      $display("FAIL load_use_stall: got pc=%b ifid=%b bub=%b required 0/0/1",
               pc_write, if_id_write, id_ex_bubble);
    end
    @(negedge clk);
    set_idle();
    #1;
    tests_run++;
    if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      fails++;
      $display("FAIL load_use_resume: got pc=%b bub=%b required 1/0", pc_write, id_ex_bubble);
    end
    tests_run++;
    if (stall_cycles !== (PERF ? 16'd1 : 16'd0)) begin
      fails++;
      $display("FAIL load_use_count: got %0d required %0d", stall_cycles, PERF ? 1 : 0);
    end
  endtask

  task automatic test_zero_reg();
    reset_pulse();
    id_ex_memRead = 1'b1; id_ex_rd = 5'd0; if_id_rs = 5'd0;
    id_uses_rt = 1'b1; id_branch = 1'b1;
    #1;
    tests_run++;
    if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      fails++;
      $display("FAIL zero_reg: got pc=%b bub=%b required 1/0", pc_write, id_ex_bubble);
    end
  endtask

  task automatic test_branch_load_flush();
    reset_pulse();
    id_branch = 1'b1; id_ex_memRead = 1'b1; id_ex_rd = 5'd9;
    if_id_rt = 5'd9; if_id_rs = 5'd3; id_uses_rt = 1'b1; branch_taken = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1 || if_id_flush !== 1'b0) begin
        fails++;
        $display("FAIL branch_load_stall%0d: got pc=%b bub=%b flush=%b required 0/1/0",
                 c, pc_write, id_ex_bubble, if_id_flush);
      end
      @(negedge clk);
    end
    id_ex_memRead = 1'b0; id_ex_rd = 5'd0;
    #1;
    tests_run++;
    if (pc_write !== 1'b1 || if_id_flush !== 1'b1) begin
      fails++;
      $display("FAIL branch_flush: got pc=%b flush=%b required 1/1", pc_write, if_id_flush);
    end
    tests_run++;
    if (stall_cycles !== (PERF ? 16'd2 : 16'd0) || flush_events !== 16'd0) begin
      fails++;
      $display("FAIL branch_load_count: got %0d/%0d required %0d/0",
               stall_cycles, flush_events, PERF ? 2 : 0);
    end
    @(negedge clk);
    set_idle();
    #1;
    tests_run++;
    if (if_id_flush !== 1'b0 || flush_events !== (PERF ? 16'd1 : 16'd0)) begin
      fails++;
      $display("FAIL flush_one_cycle: got flush=%b events=%0d required 0/%0d",
               if_id_flush, flush_events, PERF ? 1 : 0);
    end
  endtask

  task automatic test_reset_in_stall();
    reset_pulse();
    id_branch = 1'b1; id_ex_memRead = 1'b1; id_ex_rd = 5'd9;
    if_id_rt = 5'd9; id_uses_rt = 1'b1;
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1 || stall_cycles !== '0) begin
      fails++;
      $display("FAIL reset_in_stall: got pc=%b bub=%b cnt=%0d required 0/1/0",
               pc_write, id_ex_bubble, stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (pc_write !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_run: got pc=%b required 1", pc_write);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      fails++;
      $display("FAIL stall_abandoned: got pc=%b bub=%b required 1/0", pc_write, id_ex_bubble);
    end
  endtask

  task automatic test_random();
    int rem = 0, exp_stall = 0, exp_flush = 0, n;
    bit e_stall, e_flush;
    reset_pulse();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n          = ($urandom_range(0, 99) != 0);
      if_id_rs       = 5'($urandom_range(0, 3));
      if_id_rt       = 5'($urandom_range(0, 3));
      id_ex_rd       = 5'($urandom_range(0, 3));
      ex_mem_rd      = 5'($urandom_range(0, 3));
      id_uses_rt     = 1'($urandom);
      id_branch      = 1'($urandom);
      id_ex_memRead  = 1'($urandom);
      id_ex_regWrite = 1'($urandom);
      ex_mem_memRead = 1'($urandom);
      branch_taken   = 1'($urandom);
      jump           = ($urandom_range(0, 3) == 0);
      #1;
      n = required_stalls();
      if (!rst_n) begin
        rem = 0; exp_stall = 0; exp_flush = 0;
        e_stall = 1'b1; e_flush = 1'b0;
      end else if (rem > 0) begin
        e_stall = 1'b1; e_flush = 1'b0;
      end else begin
        e_stall = (n > 0);
        e_flush = !e_stall && (branch_taken || jump);
      end
      tests_run++;
      if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !==
          {!e_stall, !e_stall, e_stall, e_flush}) begin
        fails++;
        $display("FAIL rand_outputs[%0d]: got pc/ifid/bub/flush=%b required %b", i,
                 {pc_write, if_id_write, id_ex_bubble, if_id_flush},
                 {!e_stall, !e_stall, e_stall, e_flush});
      end
      tests_run++;
      if (stall_cycles !== CNT_W'(PERF ? exp_stall : 0) ||
          flush_events !== CNT_W'(PERF ? exp_flush : 0)) begin
        fails++;
        $display("FAIL rand_counters[%0d]: got %0d/%0d required %0d/%0d", i,
                 stall_cycles, flush_events, PERF ? exp_stall : 0, PERF ? exp_flush : 0);
      end
      if (rst_n) begin
        if (e_stall) exp_stall++;
        if (e_flush) exp_flush++;
        if (rem > 0) rem--;
        else if (n > 0) rem = n - 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_load_flush();
    test_reset_in_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
